// File: rtl/dcache.sv
// -----------------------------------------------------------------------------
// dcache -- direct-mapped, write-back, write-allocate data cache for the MEM
// stage of a pipelined core.
//
// A hit answers combinationally in the same cycle (loads) or updates the line at
// the clock edge (stores). A miss stalls the pipeline through `miss` while the
// FSM writes back a dirty victim (WB) and then refills the line (REFILL). Both
// phases move one 32-bit word per beat over a simple req/ack port.
//
// Backing-memory handshake: mem_req is held high for the whole WB/REFILL phase.
// mem_addr, mem_we and mem_wdata describe the current beat and stay stable until
// a cycle with mem_ack=1 completes that beat. The beat counter then advances.
// An ack outside WB/REFILL is ignored.
//
// Parameters:
//   INDEX_W  log2 of line count (2..8)
//   WORDS_W  log2 of 32-bit words per line (1..3)
//
// Ports:
//   clk, rstn                         clock (rising edge), async active-low reset
//   addr, wr_data, MemRead, MemWrite  pipeline request (held while miss=1)
//   rd_data, miss                     load data, stall request
//   mem_req, mem_we, mem_addr,
//   mem_wdata, mem_rdata, mem_ack     backing-memory beat port
//   count_cache_miss, count_wr_rd_req statistics counters
//
// Build option: define DCACHE_STATS_EN to get the miss/access counters;
// otherwise both counter outputs are tied to 0.
// -----------------------------------------------------------------------------
module dcache #(
   parameter int INDEX_W = 6,
   parameter int WORDS_W = 2
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [31:0] addr,
   input  logic [31:0] wr_data,
   input  logic        MemRead,
   input  logic        MemWrite,
   output logic [31:0] rd_data,
   output logic        miss,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic [31:0] count_cache_miss,
   output logic [31:0] count_wr_rd_req
);

   localparam int TAG_W = 32 - INDEX_W - WORDS_W - 2;
   localparam int LINES = 1 << INDEX_W;
   localparam int WORDS = 1 << WORDS_W;

   typedef enum logic [1:0] {IDLE, WB, REFILL} state_t;

   state_t state, state_next;

   logic [WORDS_W-1:0] offset;
   logic [INDEX_W-1:0] index;
   logic [TAG_W-1:0]   tag;
   logic [WORDS_W-1:0] beat;

   logic [31:0]      data_arr [LINES*WORDS];
   logic [TAG_W-1:0] tag_arr  [LINES];
   logic [LINES-1:0] valid;
   logic [LINES-1:0] dirty;

   logic req, wr_req, hit, start_miss, last_ack;

   // Byte-lane bits are not used by a word-only cache.
   logic unused_addr;
   assign unused_addr = &{1'b0, addr[1:0]};

   assign offset = addr[WORDS_W+1:2];
   assign index  = addr[WORDS_W+INDEX_W+1:WORDS_W+2];
   assign tag    = addr[31:WORDS_W+INDEX_W+2];

   // A request with both strobes high is handled as a store.
   assign req    = MemRead | MemWrite;
   assign wr_req = MemWrite;

   assign hit        = (state == IDLE) && req && valid[index] && (tag_arr[index] == tag);
   assign start_miss = (state == IDLE) && req && !hit;
   assign last_ack   = mem_ack && (&beat);
   assign rd_data    = hit ? data_arr[{index, offset}] : '0;

   // Next state and beat-port outputs. In IDLE every beat output is 0, which
   // also makes them 0 while reset holds the FSM in IDLE.
   always_comb begin
      state_next = state;
      miss       = (req && !hit) || (state != IDLE);
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      case (state)
         IDLE: begin
            if (start_miss)
               state_next = (valid[index] && dirty[index]) ? WB : REFILL;
         end
         WB: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            // Victim address is rebuilt from the stored (old) tag.
            mem_addr  = {tag_arr[index], index, beat, 2'b00};
            mem_wdata = data_arr[{index, beat}];
            if (last_ack)
               state_next = REFILL;
         end
         REFILL: begin
            mem_req  = 1'b1;
            mem_addr = {tag, index, beat, 2'b00};
            if (last_ack)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= IDLE;
         beat  <= '0;
         valid <= '0;
         dirty <= '0;
      end else begin
         state <= state_next;
         // The counter wraps to 0 on the last beat of each phase, so WB hands
         // REFILL a zero count without an explicit clear.
         if ((state != IDLE) && mem_ack)
            beat <= beat + 1'b1;
         if (hit && wr_req)
            dirty[index] <= 1'b1;
         if ((state == REFILL) && last_ack) begin
            valid[index] <= 1'b1;
            dirty[index] <= 1'b0;
         end
      end
   end

   // Data and tag storage carry no reset; valid bits gate their use.
   always_ff @(posedge clk) begin
      if (hit && wr_req)
         data_arr[{index, offset}] <= wr_data;
      if ((state == REFILL) && mem_ack)
         data_arr[{index, beat}] <= mem_rdata;
      if ((state == REFILL) && last_ack)
         tag_arr[index] <= tag;
   end

`ifdef DCACHE_STATS_EN
   logic [31:0] miss_cnt;
   logic [31:0] access_cnt;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         miss_cnt   <= '0;
         access_cnt <= '0;
      end else begin
         if (start_miss)
            miss_cnt <= miss_cnt + 32'd1;
         if (hit)
            access_cnt <= access_cnt + 32'd1;
      end
   end

   assign count_cache_miss = miss_cnt;
   assign count_wr_rd_req  = access_cnt;
`else
   assign count_cache_miss = '0;
   assign count_wr_rd_req  = '0;
`endif

endmodule
